// File: rtl/scan_display_ctrl.sv
// -----------------------------------------------------------------------------
// scan_display_ctrl
// Time-multiplexed scan of six BCD digits onto one active-low seven-segment
// bus. A snapshot of bcd_in is taken once per frame (LOAD), then each digit
// gets an all-off gap (BLANK) followed by its display slot (SHOW).
// All outputs are registered and reflect the state being entered.
//
// Optional build macro: SCAN_DISPLAY_LZB_EN enables leading-zero blanking.
// -----------------------------------------------------------------------------
module scan_display_ctrl #(
    parameter int DIV       = 50000,  // SHOW length in clock cycles (>= 1)
    parameter int BLANK_CYC = 500     // BLANK length in clock cycles (>= 1)
) (
    input  logic        clk,
    input  logic        reset,        // asynchronous, active-low
    input  logic        enable,
    input  logic [23:0] bcd_in,
    output logic [6:0]  disp,
    output logic [5:0]  dig,
    output logic        frame_tick
);

    localparam int MAX_LEN = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
    localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       idx, idx_n;
    logic             frozen, frozen_n;
    logic [23:0]      snapshot, snapshot_n;
    logic [6:0]       disp_n;
    logic [5:0]       dig_n;
    logic             tick_n;
    logic             do_load;
    logic             blank_digit;

    // Active-low segment patterns; non-BCD nibbles show a lone dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // A LOAD only takes effect on a live (enabled, not resuming) edge.
    assign do_load = enable && !frozen && (state == LOAD);

`ifdef SCAN_DISPLAY_LZB_EN
    logic [5:0] lzb_mask, lzb_mask_n;

    // A digit is blank when it and every more-significant digit are zero.
    assign lzb_mask_n[5] = (bcd_in[23:20] == 4'd0);
    assign lzb_mask_n[4] = lzb_mask_n[5] && (bcd_in[19:16] == 4'd0);
    assign lzb_mask_n[3] = lzb_mask_n[4] && (bcd_in[15:12] == 4'd0);
    assign lzb_mask_n[2] = lzb_mask_n[3] && (bcd_in[11:8]  == 4'd0);
    assign lzb_mask_n[1] = lzb_mask_n[2] && (bcd_in[7:4]   == 4'd0);
    assign lzb_mask_n[0] = 1'b0;

    // Capture the blank mask together with the snapshot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lzb_mask <= '0;
        end else if (do_load) begin
            lzb_mask <= lzb_mask_n;
        end
    end

    assign blank_digit = lzb_mask[idx];
`else
    assign blank_digit = 1'b0;
`endif

    // State register plus registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= LOAD;
            cnt        <= '0;
            idx        <= '0;
            frozen     <= 1'b0;
            // NOTE: the snapshot is reset too, so the first frame never shows
            // stale power-up contents and reset behaviour is deterministic.
            snapshot   <= '0;
            disp       <= 7'h7F;
            dig        <= 6'h3F;
            frame_tick <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every register see the
            // pre-edge values, so ordering inside this block does not matter.
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            frozen     <= frozen_n;
            snapshot   <= snapshot_n;
            disp       <= disp_n;
            dig        <= dig_n;
            frame_tick <= tick_n;
        end
    end

    // Next-state logic: freeze, resume, and the LOAD/BLANK/SHOW sequence.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_n    = state;
        cnt_n      = '0;
        idx_n      = idx;
        frozen_n   = frozen;
        snapshot_n = snapshot;

        if (!enable) begin
            frozen_n = 1'b1;
        end else if (frozen) begin
            // Resume with a full gap before the same digit, or redo the LOAD.
            frozen_n = 1'b0;
            state_n  = (state == LOAD) ? LOAD : BLANK;
        end else begin
            case (state)
                LOAD: begin
                    snapshot_n = bcd_in;
                    idx_n      = '0;
                    state_n    = BLANK;
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_n = SHOW;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        if (idx == 3'd5) begin
                            state_n = LOAD;
                        end else begin
                            idx_n   = idx + 3'd1;
                            state_n = BLANK;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: state_n = LOAD;
            endcase
        end
    end

    // Output logic: values for the state being entered on this edge.
    always_comb begin
        disp_n = 7'h7F;
        dig_n  = 6'h3F;
        tick_n = 1'b0;
        if (enable && !frozen) begin
            tick_n = (state == LOAD);
            if (state_n == SHOW) begin
                dig_n  = ~(6'b000001 << idx);
                disp_n = blank_digit ? 7'h7F
                                     : seg_decode(snapshot[{idx, 2'b00} +: 4]);
            end
        end
    end

endmodule

// File: tb/tb_scan_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scan_display_ctrl
// Scoreboard bench for scan_display_ctrl (DIV=4, BLANK_CYC=2, frame = 37).
// A reference model expands each frame into a plan of per-cycle outputs and
// pushes one expectation per clock edge; a monitor pops and compares on the
// falling edge. Honours SCAN_DISPLAY_LZB_EN for leading-zero blanking.
// -----------------------------------------------------------------------------
module tb_scan_display_ctrl;

    localparam int DIV       = 4;
    localparam int BLANK_CYC = 2;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
    };

    typedef struct packed {
        logic       tick;
        logic [5:0] dig;
        logic [6:0] disp;
    } out_t;

    typedef struct packed {
        out_t o;
        int   slot;   // digit whose BLANK/SHOW this cycle belongs to, -1 = LOAD
    } plan_t;

    localparam out_t OFF = '{tick: 1'b0, dig: 6'h3F, disp: 7'h7F};

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [23:0] bcd_in;
    logic [6:0]  disp;
    logic [5:0]  dig;
    logic        frame_tick;

    // Reference model state
    out_t        exp_q[$];
    plan_t       plan[$];
    int          cur_slot = -1;
    bit          m_frozen = 1'b0;
    logic [23:0] m_snap   = '0;
    out_t        m_last   = '{tick: 1'b0, dig: 6'h3F, disp: 7'h7F};

    int n_cmp = 0;
    int n_bad = 0;

    scan_display_ctrl #(
        .DIV       (DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .bcd_in     (bcd_in),
        .disp       (disp),
        .dig        (dig),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input out_t act, input out_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got tick=%0b dig=%h disp=%h, expected tick=%0b dig=%h disp=%h",
                     name, $time, act.tick, act.dig, act.disp, exp.tick, exp.dig, exp.disp);
        end
    endtask

    function automatic bit lzb_blank(input logic [23:0] v, input int k);
        bit b = 1'b0;
`ifdef SCAN_DISPLAY_LZB_EN
        b = (k > 0) && ((v >> (4 * k)) == 24'd0);
`endif
        return b;
    endfunction

    // Expand the rest of a frame, starting at digit 'first', into per-cycle outputs.
    task automatic build_plan(input int first, input bit with_tick);
        plan_t p;
        plan.delete();
        for (int k = first; k < 6; k++) begin
            for (int b = 0; b < BLANK_CYC; b++) begin
                p.o      = OFF;
                p.o.tick = with_tick && (k == first) && (b == 0);
                p.slot   = k;
                plan.push_back(p);
            end
            for (int s = 0; s < DIV; s++) begin
                p.o.tick = 1'b0;
                p.o.dig  = 6'(63 - (1 << k));
                p.o.disp = lzb_blank(m_snap, k) ? 7'h7F
                                                : SEG_TAB[int'((m_snap >> (4 * k)) & 24'hF)];
                p.slot   = k;
                plan.push_back(p);
            end
        end
        p.o    = OFF;
        p.slot = -1;
        plan.push_back(p);
    endtask

    // Model: one expectation per rising edge, from the inputs sampled there.
    initial begin : model
        plan_t p;
        out_t  e;
        forever begin
            @(posedge clk);
            e = OFF;
            if (!reset) begin
                plan.delete();
                cur_slot = -1;
                m_frozen = 1'b0;
                m_snap   = '0;
            end else if (!enable) begin
                m_frozen = 1'b1;
            end else if (m_frozen) begin
                m_frozen = 1'b0;
                if (cur_slot >= 0) begin
                    build_plan(cur_slot, 1'b0);
                    p        = plan.pop_front();
                    e        = p.o;
                    cur_slot = p.slot;
                end
            end else begin
                if (plan.size() == 0) begin
                    m_snap = bcd_in;
                    build_plan(0, 1'b1);
                end
                p        = plan.pop_front();
                e        = p.o;
                cur_slot = p.slot;
            end
            m_last = e;
            exp_q.push_back(e);
        end
    end

    // Monitor: compare the registered outputs mid-cycle.
    initial begin : monitor
        out_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_empty @%0t: got no expectation, expected one per cycle", $time);
            end else begin
                e = exp_q.pop_front();
                check("cycle_out", {frame_tick, dig, disp}, e);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Bounded wait until the model is in slot k, showing (want_show) or not.
    task automatic wait_slot(input int k, input bit want_show);
        int n = 0;
        while (!(cur_slot == k && ((m_last.dig != 6'h3F) == want_show)) && n < 200) begin
            cycles(1);
            n++;
        end
        if (n >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_slot%0d @%0t: got timeout after %0d cycles, expected slot reached",
                     k, $time, n);
        end
    endtask

    function automatic logic [23:0] rand_bcd();
        logic [23:0] v    = '0;
        int          lead = $urandom_range(0, 5);
        int          nib;
        for (int k = 0; k < 6; k++) begin
            nib = $urandom_range(0, 9);
            if ($urandom_range(0, 7) == 0) nib = $urandom_range(10, 15);
            if (k > lead && $urandom_range(0, 1) == 1) nib = 0;
            v[4 * k +: 4] = 4'(nib);
        end
        return v;
    endfunction

    task automatic reset_pulse(input int n);
        @(negedge clk);
        #1;
        reset = 1'b0;
        cycles(n);
        reset = 1'b1;
    endtask

    initial begin : stimulus
        reset  = 1'b0;
        enable = 1'b1;
        bcd_in = 24'h123456;

        // Reset held with enable high, then two full frames.
        cycles(5);
        reset = 1'b1;
        cycles(74);

        // New value arrives mid-frame during digit 2; takes effect next frame.
        wait_slot(2, 1'b1);
        bcd_in = 24'h999999;
        cycles(60);

        // Freeze mid-SHOW of digit 3, then resume.
        wait_slot(3, 1'b1);
        cycles(1);
        enable = 1'b0;
        cycles(10);
        enable = 1'b1;
        cycles(40);

        // Freeze while the LOAD is pending; the snapshot is deferred.
        wait_slot(-1, 1'b0);
        bcd_in = 24'h314159;
        enable = 1'b0;
        cycles(5);
        enable = 1'b1;
        cycles(45);

        // Illegal nibble, then asynchronous reset during a SHOW slot.
        bcd_in = 24'h00000A;
        cycles(40);
        wait_slot(1, 1'b1);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("async_reset", {frame_tick, dig, disp}, OFF);
        cycles(3);
        reset = 1'b1;
        cycles(40);

        // Leading-zero patterns.
        bcd_in = 24'h000070;
        cycles(80);
        bcd_in = 24'h000000;
        cycles(80);

        // Randomized mix of value changes, freezes and resets.
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 4))
                0: bcd_in = rand_bcd();
                1: begin
                    enable = 1'b0;
                    cycles($urandom_range(1, 12));
                    enable = 1'b1;
                end
                2: reset_pulse($urandom_range(1, 3));
                default: bcd_in = rand_bcd();
            endcase
            cycles($urandom_range(1, 40));
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
